// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the SIPO frame buffer
// Purpose: FSM state encoding and fill-counter width helper.
package sipo_pkg;

  // FILL: collecting words; HOLD: a complete frame is presented on o_out
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } sipo_state_e;

  // Counter must reach NINPUTS in the double-buffered build, so size for n+1 values
  function automatic int sipo_cwidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - enable-driven word shift register
// Purpose: shifts i_data in at index NINPUTS-1, older words move toward index 0.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (contents -> 0)
//   i_clear  synchronous clear (contents -> 0), overrides i_en
//   i_en     shift one word in
//   i_data   word to shift in
//   o_sr     register contents, o_sr[0] = oldest word
module sipo_shift_core #(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic                            i_en,
  input  logic [IWIDTH-1:0]               i_data,
  output logic [NINPUTS-1:0][IWIDTH-1:0]  o_sr
);

  logic [NINPUTS-1:0][IWIDTH-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= {i_data, r_sr[NINPUTS-1:1]};
    end
  end

  assign o_sr = r_sr;

endmodule

// File: rtl/sipo_frame_buffer.sv
// rtl/sipo_frame_buffer.sv - serial-in/parallel-out frame collector with handshakes
// Purpose: gathers NINPUTS words into a frame, presents it until consumed.
// Build option: SIPO_DOUBLE_BUFFER_EN adds a separate output frame register so
// filling continues while a frame is held.
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_clear        synchronous flush of partial and held frame
//   i_in_valid     input word valid
//   o_in_ready     block accepts a word this cycle
//   i_in           input word
//   o_frame_valid  o_out holds a complete frame
//   i_frame_ready  downstream consumes the frame this cycle
//   o_out          frame, o_out[0] = first word received
//   o_fill_count   words accepted into the current partial frame
module sipo_frame_buffer
  import sipo_pkg::*;
#(
  parameter  int IWIDTH  = 10,
  parameter  int NINPUTS = 8,
  localparam int CWIDTH  = sipo_cwidth(NINPUTS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [IWIDTH-1:0]               i_in,
  output logic                            o_frame_valid,
  input  logic                            i_frame_ready,
  output logic [NINPUTS-1:0][IWIDTH-1:0]  o_out,
  output logic [CWIDTH-1:0]               o_fill_count
);

  localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(NINPUTS - 1);
  localparam logic [CWIDTH-1:0] FULL_CNT = CWIDTH'(NINPUTS);

  sipo_state_e r_state, w_state_nxt;
  logic [CWIDTH-1:0] r_count, w_count_nxt;
  logic r_alive;  // holds o_in_ready low for the first cycle after reset release
  logic w_accept, w_consume, w_last;
  logic [NINPUTS-1:0][IWIDTH-1:0] w_sr;

  assign w_accept  = i_in_valid & o_in_ready & ~i_clear;
  assign w_consume = (r_state == HOLD) & i_frame_ready;
  assign w_last    = w_accept & (r_count == LAST_IDX);
  assign o_frame_valid = (r_state == HOLD);
  assign o_fill_count  = r_count;

  sipo_shift_core #(
    .IWIDTH (IWIDTH),
    .NINPUTS(NINPUTS)
  ) u_core (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(i_clear),
    .i_en   (w_accept),
    .i_data (i_in),
    .o_sr   (w_sr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alive <= 1'b0;
      r_state <= FILL;
      r_count <= '0;
    end else begin
      r_alive <= 1'b1;
      if (i_clear) begin
        r_state <= FILL;
        r_count <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_count <= w_count_nxt;
      end
    end
  end

`ifdef SIPO_DOUBLE_BUFFER_EN
  logic [NINPUTS-1:0][IWIDTH-1:0] r_out;
  logic [NINPUTS-1:0][IWIDTH-1:0] w_next_frame;
  logic w_load_new, w_load_full;

  // The frame as it will look after this accept; lets the copy skip a bubble.
  assign w_next_frame = {i_in, w_sr[NINPUTS-1:1]};
  assign o_in_ready   = r_alive & (r_count != FULL_CNT);
  assign o_out        = r_out;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load_new  = 1'b0;
    w_load_full = 1'b0;
    if (w_consume) w_state_nxt = FILL;
    if (w_accept)  w_count_nxt = r_count + 1'b1;
    // Completed frame goes straight out when the output slot is free this cycle;
    // otherwise the count parks at NINPUTS and blocks input.
    if (w_last && ((r_state == FILL) || i_frame_ready)) begin
      w_count_nxt = '0;
      w_load_new  = 1'b1;
      w_state_nxt = HOLD;
    end
    if ((r_count == FULL_CNT) && w_consume) begin
      w_count_nxt = '0;
      w_load_full = 1'b1;
      w_state_nxt = HOLD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out <= '0;
    end else if (i_clear) begin
      r_out <= '0;
    end else if (w_load_new) begin
      r_out <= w_next_frame;
    end else if (w_load_full) begin
      r_out <= w_sr;
    end
  end
`else
  assign o_in_ready = r_alive & (r_state == FILL);
  assign o_out      = w_sr;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_consume) w_state_nxt = FILL;
    if (w_accept) begin
      if (w_last) begin
        w_count_nxt = '0;
        w_state_nxt = HOLD;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end
  end
`endif

endmodule
